// File: rtl/data_sram_bridge_pkg.sv
// Shared types for the data-side SRAM bridge: FSM state encoding and
// access-size codes carried on data_size / req_size.
// Imported by the bridge and its testbench.
package data_sram_bridge_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_WAIT = 2'd2,
    ST_DONE = 2'd3
  } bridge_state_t;

  localparam logic [2:0] SIZE_BYTE = 3'd0;
  localparam logic [2:0] SIZE_HALF = 3'd1;
  localparam logic [2:0] SIZE_WORD = 3'd2;

endpackage

// File: rtl/data_sram_bridge.sv
// Bridges memory-stage data accesses onto a valid/ready request bus with a response channel.
// Latency: 3 cycles mem_en-to-DONE minimum; +1 per req_ready-low cycle, +1 per cycle of response delay.
// Backpressure: stall freezes the pipeline until DONE; request payload is frozen until accepted.
module data_sram_bridge
  import data_sram_bridge_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        mem_en,
  input  logic [3:0]  mem_wen,
  input  logic [31:0] mem_addr,
  input  logic [31:0] mem_wdata,
  input  logic [2:0]  data_size,
  output logic [31:0] mem_rdata,
  output logic        stall,
  output logic        req_valid,
  input  logic        req_ready,
  output logic        req_wr,
  output logic [31:0] req_addr,
  output logic [2:0]  req_size,
  output logic [3:0]  req_wstrb,
  output logic [31:0] req_wdata,
  input  logic        resp_valid,
  input  logic [31:0] resp_rdata
);

  bridge_state_t r_state;
  logic          r_req_valid;
  logic [3:0]    r_wen;
  logic [31:0]   r_addr;
  logic [31:0]   r_wdata;
  logic [2:0]    r_size;
  logic [31:0]   r_rdata;

  logic          w_accept;
  logic          w_is_store;

  assign w_accept   = r_req_valid & req_ready;
  assign w_is_store = |r_wen;

  // Access FSM: owns the latched payload, the request-valid flag and the load-data register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_req_valid <= 1'b0;
      r_wen       <= '0;
      r_addr      <= '0;
      r_wdata     <= '0;
      r_size      <= '0;
      r_rdata     <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (mem_en) begin
            // Snapshot the access so the bus payload cannot follow pipeline changes.
            r_wen       <= mem_wen;
            r_addr      <= mem_addr;
            r_wdata     <= mem_wdata;
            r_size      <= data_size;
            r_req_valid <= 1'b1;
            r_state     <= ST_REQ;
          end
        end
        ST_REQ: begin
          if (w_accept) begin
            r_req_valid <= 1'b0;
            r_state     <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (resp_valid) begin
            // Stores also get a response, but it carries no data for the pipeline.
            if (!w_is_store) begin
              r_rdata <= resp_rdata;
            end
            r_state <= ST_DONE;
          end
        end
        ST_DONE: begin
          // One cycle with stall low lets the pipeline advance exactly once.
          r_state <= ST_IDLE;
        end
        default: begin
          r_req_valid <= 1'b0;
          r_state     <= ST_IDLE;
        end
      endcase
    end
  end

  // Stall covers the request cycle in IDLE so the pipeline never runs past an access.
  always_comb begin
    stall = 1'b0;
    case (r_state)
      ST_IDLE: stall = mem_en;
      ST_REQ:  stall = 1'b1;
      ST_WAIT: stall = 1'b1;
      default: stall = 1'b0;
    endcase
  end

  assign req_valid = r_req_valid;
  assign req_wr    = w_is_store;
  assign req_addr  = r_addr;
  assign req_size  = r_size;
  assign req_wstrb = r_wen;
  assign req_wdata = r_wdata;
  assign mem_rdata = r_rdata;

endmodule

// File: tb/tb_data_sram_bridge.sv
// Directed self-checking bench for data_sram_bridge.
// Walks load, backpressured store, slow response, reset mid-WAIT and back-to-back accesses.
// Inputs change 1 time unit after the rising edge; outputs are checked 2 units after it.
module tb_data_sram_bridge;
  import data_sram_bridge_pkg::*;

  logic        clk;
  logic        rst;
  logic        mem_en;
  logic [3:0]  mem_wen;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [2:0]  data_size;
  logic [31:0] mem_rdata;
  logic        stall;
  logic        req_valid;
  logic        req_ready;
  logic        req_wr;
  logic [31:0] req_addr;
  logic [2:0]  req_size;
  logic [3:0]  req_wstrb;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic [31:0] resp_rdata;

  int total;
  int bad;

  data_sram_bridge dut (
    .clk        (clk),
    .rst        (rst),
    .mem_en     (mem_en),
    .mem_wen    (mem_wen),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .data_size  (data_size),
    .mem_rdata  (mem_rdata),
    .stall      (stall),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_wr     (req_wr),
    .req_addr   (req_addr),
    .req_size   (req_size),
    .req_wstrb  (req_wstrb),
    .req_wdata  (req_wdata),
    .resp_valid (resp_valid),
    .resp_rdata (resp_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Advance to 1 unit after the next rising edge (input drive point).
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  initial begin
    total      = 0;
    bad        = 0;
    rst        = 1'b1;
    mem_en     = 1'b0;
    mem_wen    = 4'b0000;
    mem_addr   = 32'h0;
    mem_wdata  = 32'h0;
    data_size  = SIZE_BYTE;
    req_ready  = 1'b0;
    resp_valid = 1'b0;
    resp_rdata = 32'h0;

    // ---------------- reset state ----------------
    cyc(); cyc();
    #1;
    chk("rst_state",     32'(dut.r_state), 32'(ST_IDLE));
    chk("rst_stall",     32'(stall), 32'd0);
    chk("rst_req_valid", 32'(req_valid), 32'd0);
    chk("rst_rdata",     mem_rdata, 32'h0);
    chk("rst_req_addr",  req_addr, 32'h0);
    chk("rst_wstrb",     32'(req_wstrb), 32'h0);
    rst = 1'b0;

    // ---------------- single load ----------------
    cyc();
    mem_en = 1'b1; mem_wen = 4'b0000; mem_addr = 32'h8000_1004;
    data_size = SIZE_WORD; req_ready = 1'b1;
    #1;
    chk("ld_idle_stall", 32'(stall), 32'd1);
    chk("ld_idle_rv",    32'(req_valid), 32'd0);
    cyc(); #1;                                    // REQ
    chk("ld_req_stall",  32'(stall), 32'd1);
    chk("ld_req_rv",     32'(req_valid), 32'd1);
    chk("ld_req_addr",   req_addr, 32'h8000_1004);
    chk("ld_req_wr",     32'(req_wr), 32'd0);
    chk("ld_req_size",   32'(req_size), 32'(SIZE_WORD));
    cyc();                                        // WAIT
    resp_valid = 1'b1; resp_rdata = 32'hDEAD_BEEF;
    #1;
    chk("ld_wait_stall", 32'(stall), 32'd1);
    chk("ld_wait_rv",    32'(req_valid), 32'd0);
    cyc();                                        // DONE
    resp_valid = 1'b0; resp_rdata = 32'h0;
    #1;
    chk("ld_done_stall", 32'(stall), 32'd0);
    chk("ld_done_rdata", mem_rdata, 32'hDEAD_BEEF);
    mem_en = 1'b0;
    cyc(); #1;                                    // IDLE
    chk("ld_idle2_stall", 32'(stall), 32'd0);
    chk("ld_idle2_rdata", mem_rdata, 32'hDEAD_BEEF);

    // ---------------- store under backpressure ----------------
    mem_en = 1'b1; mem_wen = 4'b0100; mem_addr = 32'h8000_2002;
    mem_wdata = 32'h00AB_0000; data_size = SIZE_BYTE; req_ready = 1'b0;
    cyc();                                        // REQ, ready low for 4 cycles
    mem_wen = 4'b1111; mem_addr = 32'h5555_5555; mem_wdata = 32'hFFFF_FFFF;
    data_size = SIZE_WORD;
    for (int i = 0; i < 4; i++) begin
      #1;
      chk("st_bp_rv",    32'(req_valid), 32'd1);
      chk("st_bp_wr",    32'(req_wr), 32'd1);
      chk("st_bp_wstrb", 32'(req_wstrb), 32'b0100);
      chk("st_bp_size",  32'(req_size), 32'(SIZE_BYTE));
      chk("st_bp_addr",  req_addr, 32'h8000_2002);
      chk("st_bp_wdata", req_wdata, 32'h00AB_0000);
      chk("st_bp_stall", 32'(stall), 32'd1);
      cyc();
    end
    req_ready = 1'b1;                             // fifth REQ cycle: accepted
    #1;
    chk("st_acc_rv",    32'(req_valid), 32'd1);
    chk("st_acc_wstrb", 32'(req_wstrb), 32'b0100);
    cyc();                                        // WAIT
    resp_valid = 1'b1; resp_rdata = 32'h1234_5678;
    #1;
    chk("st_wait_rv", 32'(req_valid), 32'd0);
    cyc();                                        // DONE
    resp_valid = 1'b0;
    #1;
    chk("st_done_stall", 32'(stall), 32'd0);
    chk("st_done_rdata", mem_rdata, 32'hDEAD_BEEF);
    mem_en = 1'b0;
    cyc();                                        // IDLE

    // ---------------- slow response, stray pulses ignored ----------------
    resp_valid = 1'b1; resp_rdata = 32'hBAD0_BAD0;   // pulse in IDLE, no request
    cyc();
    resp_valid = 1'b0;
    #1;
    chk("sl_idle_rv",    32'(req_valid), 32'd0);
    chk("sl_idle_stall", 32'(stall), 32'd0);
    chk("sl_idle_rdata", mem_rdata, 32'hDEAD_BEEF);
    mem_en = 1'b1; mem_wen = 4'b0000; mem_addr = 32'h0000_0010;
    data_size = SIZE_HALF; req_ready = 1'b1;
    cyc();                                        // REQ
    resp_valid = 1'b1;                            // pulse in REQ: ignored
    #1;
    chk("sl_req_rv", 32'(req_valid), 32'd1);
    cyc();                                        // WAIT
    resp_valid = 1'b0;
    for (int i = 0; i < 10; i++) begin
      #1;
      chk("sl_wait_stall", 32'(stall), 32'd1);
      chk("sl_wait_rv",    32'(req_valid), 32'd0);
      chk("sl_wait_rdata", mem_rdata, 32'hDEAD_BEEF);
      cyc();
    end
    resp_valid = 1'b1; resp_rdata = 32'hCAFE_F00D;
    #1;
    chk("sl_last_stall", 32'(stall), 32'd1);
    cyc();                                        // DONE
    resp_valid = 1'b0;
    #1;
    chk("sl_done_stall", 32'(stall), 32'd0);
    chk("sl_done_rdata", mem_rdata, 32'hCAFE_F00D);
    mem_en = 1'b0;
    cyc();                                        // IDLE

    // ---------------- reset mid-WAIT ----------------
    mem_en = 1'b1; mem_wen = 4'b0000; mem_addr = 32'h0000_0020;
    data_size = SIZE_WORD; req_ready = 1'b1;
    cyc();                                        // REQ
    cyc();                                        // WAIT
    cyc();                                        // WAIT
    #1;
    chk("rw_wait_stall", 32'(stall), 32'd1);
    rst = 1'b1;
    #1;
    chk("rw_state",     32'(dut.r_state), 32'(ST_IDLE));
    chk("rw_rv",        32'(req_valid), 32'd0);
    chk("rw_rdata",     mem_rdata, 32'h0);
    chk("rw_stall_en1", 32'(stall), 32'd1);       // IDLE with mem_en still high
    mem_en = 1'b0;
    #1;
    chk("rw_stall_en0", 32'(stall), 32'd0);
    cyc();
    rst = 1'b0;
    resp_valid = 1'b1; resp_rdata = 32'h7777_7777;
    cyc();
    resp_valid = 1'b0;
    #1;
    chk("rw_stray_state", 32'(dut.r_state), 32'(ST_IDLE));
    chk("rw_stray_rdata", mem_rdata, 32'h0);
    chk("rw_stray_rv",    32'(req_valid), 32'd0);
    chk("rw_stray_stall", 32'(stall), 32'd0);

    // ---------------- back-to-back accesses ----------------
    mem_en = 1'b1; mem_wen = 4'b0000; mem_addr = 32'h0000_0100;
    data_size = SIZE_WORD; req_ready = 1'b1;
    cyc(); #1;                                    // REQ #1
    chk("bb_req1_rv",   32'(req_valid), 32'd1);
    chk("bb_req1_addr", req_addr, 32'h0000_0100);
    cyc();                                        // WAIT #1
    resp_valid = 1'b1; resp_rdata = 32'h1111_1111;
    #1;
    chk("bb_wait1_rv", 32'(req_valid), 32'd0);
    cyc();                                        // DONE #1, mem_en still high
    resp_valid = 1'b0;
    mem_addr = 32'h0000_0200;
    #1;
    chk("bb_done1_stall", 32'(stall), 32'd0);
    chk("bb_done1_rv",    32'(req_valid), 32'd0);
    chk("bb_done1_rdata", mem_rdata, 32'h1111_1111);
    cyc(); #1;                                    // IDLE
    chk("bb_idle_stall", 32'(stall), 32'd1);
    chk("bb_idle_rv",    32'(req_valid), 32'd0);
    cyc(); #1;                                    // REQ #2, 2 cycles after DONE
    chk("bb_req2_rv",   32'(req_valid), 32'd1);
    chk("bb_req2_addr", req_addr, 32'h0000_0200);
    cyc();                                        // WAIT #2
    resp_valid = 1'b1; resp_rdata = 32'h2222_2222;
    #1;
    chk("bb_wait2_rv", 32'(req_valid), 32'd0);
    cyc();                                        // DONE #2
    resp_valid = 1'b0;
    mem_en = 1'b0;
    #1;
    chk("bb_done2_stall", 32'(stall), 32'd0);
    chk("bb_done2_rdata", mem_rdata, 32'h2222_2222);
    cyc(); #1;                                    // IDLE, no third request
    chk("bb_end_rv",    32'(req_valid), 32'd0);
    chk("bb_end_stall", 32'(stall), 32'd0);
    cyc(); #1;
    chk("bb_end2_rv",   32'(req_valid), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
